// File: rtl/pingpong_bank_reader_if.sv
// Bank-read and output-stream signals of the ping-pong read engine.
// master = the read engine, slave = bank storage, writer control and consumer.
interface pingpong_bank_reader_if #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned ADDRW = 3
) ();
    logic             start;
    logic             fulla;
    logic             fullb;
    logic [DATAW-1:0] rdataa;
    logic [DATAW-1:0] rdatab;
    logic             outready;
    logic [ADDRW-1:0] rdaddr;
    logic             rena;
    logic             renb;
    logic [DATAW-1:0] outdata;
    logic             outvalid;
    logic             releasea;
    logic             releaseb;
    logic             complete;
    logic             bsel;

    modport master (
        input  start, fulla, fullb, rdataa, rdatab, outready,
        output rdaddr, rena, renb, outdata, outvalid, releasea, releaseb, complete, bsel
    );

    modport slave (
        output start, fulla, fullb, rdataa, rdatab, outready,
        input  rdaddr, rena, renb, outdata, outvalid, releasea, releaseb, complete, bsel
    );
endinterface

// File: rtl/pingpong_bank_reader.sv
// Drains the filled ping-pong bank (strict A->B order) onto a valid/ready stream,
// then pulses a release for that bank.
module pingpong_bank_reader #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned ADDRW = 3
) (
    input logic                    readclk,
    input logic                    reset,
    pingpong_bank_reader_if.master bus
);

    typedef enum logic [1:0] {StWaitBank, StRead, StRelease} state_e;

    // Issue counter runs 0..Depth, hence one bit wider than the address.
    localparam logic [ADDRW:0] Depth = {1'b1, {ADDRW{1'b0}}};

    state_e           state_q, state_d;
    logic [ADDRW:0]   cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic             bsel_q, bsel_d;
    logic [DATAW-1:0] outdata_q, outdata_d;
    logic             outvalid_q, outvalid_d;

    logic issue;
    logic xfer;
    logic last_xfer;
    logic rena, renb, releasea, releaseb, complete;

    assign xfer      = outvalid_q && bus.outready;
    assign last_xfer = xfer && (cnt_q == Depth) && !inflight_q;
    assign issue     = (state_q == StRead) && !inflight_q &&
                       (!outvalid_q || bus.outready) && (cnt_q != Depth);

    always_ff @(posedge readclk) begin
        if (reset) begin
            state_q <= StWaitBank;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitBank: begin
                // Only the expected bank may start a drain, so banks are never skipped.
                if (bus.start && (bsel_q ? bus.fullb : bus.fulla)) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (last_xfer) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StWaitBank;
            default:   state_d = StWaitBank;
        endcase
    end

    always_comb begin
        rena     = issue && !bsel_q;
        renb     = issue && bsel_q;
        releasea = (state_q == StRelease) && !bsel_q;
        releaseb = (state_q == StRelease) && bsel_q;
        complete = (state_q == StRelease);
    end

    always_comb begin
        cnt_d      = cnt_q;
        inflight_d = issue;
        bsel_d     = bsel_q;
        outdata_d  = outdata_q;
        outvalid_d = outvalid_q;

        if (issue) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == StRelease) begin
            cnt_d  = '0;
            bsel_d = ~bsel_q;
        end

        // Read data arrives one cycle after the strobe; the output slot is always free then.
        if (inflight_q) begin
            outdata_d  = bsel_q ? bus.rdatab : bus.rdataa;
            outvalid_d = 1'b1;
        end else if (xfer) begin
            outvalid_d = 1'b0;
        end
    end

    always_ff @(posedge readclk) begin
        if (reset) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            bsel_q     <= 1'b0;
            outdata_q  <= '0;
            outvalid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            bsel_q     <= bsel_d;
            outdata_q  <= outdata_d;
            outvalid_q <= outvalid_d;
        end
    end

    assign bus.rdaddr   = cnt_q[ADDRW-1:0];
    assign bus.rena     = rena;
    assign bus.renb     = renb;
    assign bus.outdata  = outdata_q;
    assign bus.outvalid = outvalid_q;
    assign bus.releasea = releasea;
    assign bus.releaseb = releaseb;
    assign bus.complete = complete;
    assign bus.bsel     = bsel_q;

endmodule

// File: tb/tb_pingpong_bank_reader.sv
// Self-checking bench for pingpong_bank_reader: bank memory models, a word scoreboard
// and cycle-accurate timing checks.
module tb_pingpong_bank_reader;

    localparam int unsigned DATAW = 8;
    localparam int unsigned ADDRW = 3;
    localparam int unsigned DEPTH = 2 ** ADDRW;

    logic readclk = 1'b0;
    logic reset   = 1'b1;
    int   cycle   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DATAW-1:0] mema [DEPTH];
    logic [DATAW-1:0] memb [DEPTH];
    logic [DATAW-1:0] sb_q [$];

    pingpong_bank_reader_if #(.DATAW(DATAW), .ADDRW(ADDRW)) u_if ();

    pingpong_bank_reader #(.DATAW(DATAW), .ADDRW(ADDRW)) u_dut (
        .readclk (readclk),
        .reset   (reset),
        .bus     (u_if.master)
    );

    always #5 readclk = ~readclk;
    always @(posedge readclk) cycle <= cycle + 1;

    // Synchronous-read bank storage.
    always @(posedge readclk) begin
        if (u_if.rena) u_if.rdataa <= mema[u_if.rdaddr];
        if (u_if.renb) u_if.rdatab <= memb[u_if.rdaddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Scoreboard: every accepted word must be the next one queued.
    always @(negedge readclk) begin
        if (!reset) begin
            if (u_if.rena || u_if.renb) check_eq("ren_excl", {31'd0, u_if.rena && u_if.renb}, 0);
            if (u_if.outvalid && u_if.outready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_extra_word", {24'd0, u_if.outdata}, 32'hffff_ffff);
                end else begin
                    check_eq("sb_word", {24'd0, u_if.outdata}, {24'd0, sb_q.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge readclk);
        #1;
    endtask

    task automatic push_bank(input bit b);
        for (int k = 0; k < DEPTH; k++) sb_q.push_back(b ? memb[k] : mema[k]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdaddr"},   {29'd0, u_if.rdaddr}, 0);
        check_eq({tag, "_rena"},     {31'd0, u_if.rena}, 0);
        check_eq({tag, "_renb"},     {31'd0, u_if.renb}, 0);
        check_eq({tag, "_outdata"},  {24'd0, u_if.outdata}, 0);
        check_eq({tag, "_outvalid"}, {31'd0, u_if.outvalid}, 0);
        check_eq({tag, "_releasea"}, {31'd0, u_if.releasea}, 0);
        check_eq({tag, "_releaseb"}, {31'd0, u_if.releaseb}, 0);
        check_eq({tag, "_complete"}, {31'd0, u_if.complete}, 0);
        check_eq({tag, "_bsel"},     {31'd0, u_if.bsel}, 0);
    endtask

    task automatic do_reset(input string tag);
        step();
        reset = 1'b1;
        repeat (2) @(posedge readclk);
        #1;
        reset = 1'b0;
        @(negedge readclk);
        check_reset_outputs(tag);
    endtask

    // Returns the cycle of the release pulse for bank b, or -1 on timeout.
    task automatic wait_release(input bit b, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge readclk);
            if (b ? u_if.releaseb : u_if.releasea) begin
                at = cycle;
                check_eq("complete_with_release", {31'd0, u_if.complete}, 1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int at;
        int u;

        for (int k = 0; k < DEPTH; k++) begin
            mema[k] = 8'h10 + 8'(k);
            memb[k] = 8'hA0 + 8'(k);
        end
        u_if.start    = 1'b0;
        u_if.fulla    = 1'b0;
        u_if.fullb    = 1'b0;
        u_if.outready = 1'b0;
        u_if.rdataa   = '0;
        u_if.rdatab   = '0;

        // Power-on reset, some idle, then a 2-cycle reset mid-idle.
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        do_reset("rst");

        // Full-rate drain of bank A.
        step();
        t = cycle;
        push_bank(1'b0);
        u_if.start    = 1'b1;
        u_if.fulla    = 1'b1;
        u_if.outready = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            @(negedge readclk);
            check_eq("a_rena", {31'd0, u_if.rena}, {31'd0, (c % 2 == 1) && (c <= 15)});
            check_eq("a_renb", {31'd0, u_if.renb}, 0);
            if ((c % 2 == 1) && (c <= 15)) check_eq("a_rdaddr", {29'd0, u_if.rdaddr}, (c - 1) / 2);
            check_eq("a_outvalid", {31'd0, u_if.outvalid},
                     {31'd0, (c % 2 == 1) && (c >= 3) && (c <= 17)});
            if ((c % 2 == 1) && (c >= 3) && (c <= 17))
                check_eq("a_outdata", {24'd0, u_if.outdata}, 32'h10 + (c - 3) / 2);
            check_eq("a_releasea", {31'd0, u_if.releasea}, {31'd0, c == 18});
            check_eq("a_complete", {31'd0, u_if.complete}, {31'd0, c == 18});
            check_eq("a_bsel", {31'd0, u_if.bsel}, {31'd0, c == 19});
        end
        step();
        u_if.start = 1'b0;
        u_if.fulla = 1'b0;
        check_eq("a_sb_empty", sb_q.size(), 0);
        do_reset("rst2");

        // Backpressure: 5 stall cycles while word 0x12 is presented.
        step();
        t = cycle;
        push_bank(1'b0);
        u_if.start = 1'b1;
        u_if.fulla = 1'b1;
        repeat (7) @(posedge readclk);
        #1;
        u_if.outready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge readclk);
            check_eq("bp_outvalid", {31'd0, u_if.outvalid}, 1);
            check_eq("bp_outdata", {24'd0, u_if.outdata}, 32'h12);
            check_eq("bp_no_ren", {31'd0, u_if.rena || u_if.renb}, 0);
            step();
        end
        u_if.outready = 1'b1;
        wait_release(1'b0, 50, at);
        check_eq("bp_releasea_cycle", at, t + 23);
        step();
        u_if.start = 1'b0;
        u_if.fulla = 1'b0;
        check_eq("bp_sb_empty", sb_q.size(), 0);
        do_reset("rst3");

        // Bank order: B alone must not start while A is expected.
        step();
        u_if.start = 1'b1;
        u_if.fullb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge readclk);
            check_eq("ord_no_renb", {31'd0, u_if.renb}, 0);
            check_eq("ord_no_rena", {31'd0, u_if.rena}, 0);
            check_eq("ord_no_outvalid", {31'd0, u_if.outvalid}, 0);
        end
        step();
        push_bank(1'b0);
        push_bank(1'b1);
        u_if.fulla = 1'b1;
        wait_release(1'b0, 60, at);
        check_eq("ord_releasea_seen", {31'd0, at >= 0}, 1);
        step();
        u_if.fulla = 1'b0;
        @(negedge readclk);
        check_eq("ord_bsel_b", {31'd0, u_if.bsel}, 1);
        wait_release(1'b1, 60, at);
        check_eq("ord_releaseb_seen", {31'd0, at >= 0}, 1);
        @(negedge readclk);
        check_eq("ord_bsel_back", {31'd0, u_if.bsel}, 0);
        step();
        u_if.start = 1'b0;
        u_if.fullb = 1'b0;
        check_eq("ord_sb_empty", sb_q.size(), 0);

        // Reset in the cycle after word 4 is accepted (word 4 valid in t+11).
        step();
        t = cycle;
        push_bank(1'b0);
        u_if.start = 1'b1;
        u_if.fulla = 1'b1;
        repeat (12) @(posedge readclk);
        #1;
        check_eq("mr_words_left", sb_q.size(), 3);
        sb_q.delete();
        reset      = 1'b1;
        u_if.start = 1'b0;
        step();
        reset = 1'b0;
        @(negedge readclk);
        check_reset_outputs("mr");

        // Gating: fulla stays high with start low, so nothing may be read.
        for (int i = 0; i < 10; i++) begin
            @(negedge readclk);
            check_eq("gate_no_rena", {31'd0, u_if.rena}, 0);
            check_eq("gate_no_releasea", {31'd0, u_if.releasea}, 0);
            check_eq("gate_no_outvalid", {31'd0, u_if.outvalid}, 0);
        end
        step();
        u = cycle;
        push_bank(1'b0);
        u_if.start = 1'b1;
        @(negedge readclk);
        check_eq("gate_rena_u", {31'd0, u_if.rena}, 0);
        @(negedge readclk);
        check_eq("gate_cycle", cycle, u + 1);
        check_eq("gate_rena_u1", {31'd0, u_if.rena}, 1);
        check_eq("gate_rdaddr_u1", {29'd0, u_if.rdaddr}, 0);
        wait_release(1'b0, 60, at);
        check_eq("gate_releasea_cycle", at, u + 18);
        step();
        u_if.start = 1'b0;
        u_if.fulla = 1'b0;
        repeat (3) step();
        check_eq("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
